// File: rtl/bicubic_window_buffer.sv
// bicubic_window_buffer
//   Turns a raster-order pixel stream into 4x4 source windows for the
//   bicubic upsampler. Three line buffers supply the three older rows of the
//   current column, and a 4x4 shift register builds the window one column at
//   a time. Each complete window is held until the upsampler has produced
//   all 16 output phases. Input is stalled for that whole time.
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    source pixel handshake, in_pixel = pixel data
//   bf_req_valid         window valid (upsampler request valid)
//   bcci_req_ready       upsampler request ready
//   rsp_beat             one upsampler output handshake
//   p1..p16              window, p(4i+j+1) = row i (0 = oldest), column j
module bicubic_window_buffer #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int IMG_WIDTH     = 960,
  parameter int IMG_HEIGHT    = 540,
  parameter int COL_W         = 10,
  parameter int ROW_W         = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNEL_WIDTH-1:0] in_pixel,
  output logic                     bf_req_valid,
  input  logic                     bcci_req_ready,
  input  logic                     rsp_beat,
  output logic [CHANNEL_WIDTH-1:0] p1,  p2,  p3,  p4,
  output logic [CHANNEL_WIDTH-1:0] p5,  p6,  p7,  p8,
  output logic [CHANNEL_WIDTH-1:0] p9,  p10, p11, p12,
  output logic [CHANNEL_WIDTH-1:0] p13, p14, p15, p16
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                               state_q, state_d;
  logic [COL_W-1:0]                     col_q, col_d;
  logic [ROW_W-1:0]                     row_q, row_d;
  logic [3:0]                           beat_cnt_q, beat_cnt_d;
  logic [3:0][3:0][CHANNEL_WIDTH-1:0]   win_q, win_d;

  // lb0 = row r-1, lb1 = row r-2, lb2 = row r-3 at the current column
  logic [CHANNEL_WIDTH-1:0] lb0_mem [IMG_WIDTH];
  logic [CHANNEL_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [CHANNEL_WIDTH-1:0] lb2_mem [IMG_WIDTH];

  logic accept, beat, col_last, row_last;

  assign bf_req_valid = (state_q == HOLD);
  assign in_ready     = !bf_req_valid;
  assign accept       = in_valid && in_ready;
  assign col_last     = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last     = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // The first beat of a window is only valid together with request
  // acceptance; later beats need no ready.
  assign beat = bf_req_valid && rsp_beat && ((beat_cnt_q != 4'd0) || bcci_req_ready);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    beat_cnt_d = beat_cnt_q;
    win_d      = win_q;
    if (accept) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 3; j++)
          win_d[i][j] = win_q[i][j+1];
      win_d[0][3] = lb2_mem[col_q];
      win_d[1][3] = lb1_mem[col_q];
      win_d[2][3] = lb0_mem[col_q];
      win_d[3][3] = in_pixel;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Columns 0..2 / rows 0..2 still hold data from the previous line or
      // frame, so only windows ending at c>=3, r>=3 are emitted.
      if (col_q >= COL_W'(3) && row_q >= ROW_W'(3))
        state_d = HOLD;
    end
    if (beat) begin
      if (beat_cnt_q == 4'd15) begin
        state_d    = IDLE;
        beat_cnt_d = 4'd0;
      end else begin
        beat_cnt_d = beat_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      beat_cnt_q <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      beat_cnt_q <= beat_cnt_d;
      win_q      <= win_d;
    end
  end

  // Line buffer storage is not reset: rows 0..2 of each frame refill it
  // before any window can reach the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_mem[col_q] <= lb1_mem[col_q];
      lb1_mem[col_q] <= lb0_mem[col_q];
      lb0_mem[col_q] <= in_pixel;
    end
  end

  assign p1  = win_q[0][0];  assign p2  = win_q[0][1];
  assign p3  = win_q[0][2];  assign p4  = win_q[0][3];
  assign p5  = win_q[1][0];  assign p6  = win_q[1][1];
  assign p7  = win_q[1][2];  assign p8  = win_q[1][3];
  assign p9  = win_q[2][0];  assign p10 = win_q[2][1];
  assign p11 = win_q[2][2];  assign p12 = win_q[2][3];
  assign p13 = win_q[3][0];  assign p14 = win_q[3][1];
  assign p15 = win_q[3][2];  assign p16 = win_q[3][3];

endmodule

// File: tb/tb_bicubic_window_buffer.sv
module tb_bicubic_window_buffer;
  localparam int CW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int FRAME = W * H;

  typedef logic [15:0][CW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_pixel = '0;
  logic          bf_req_valid;
  logic          bcci_req_ready = 1'b0;
  logic          rsp_beat = 1'b0;
  win_t          pv;

  bicubic_window_buffer #(
    .CHANNEL_WIDTH(CW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(3), .ROW_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .bf_req_valid(bf_req_valid),
    .bcci_req_ready(bcci_req_ready), .rsp_beat(rsp_beat),
    .p1(pv[0]),   .p2(pv[1]),   .p3(pv[2]),   .p4(pv[3]),
    .p5(pv[4]),   .p6(pv[5]),   .p7(pv[6]),   .p8(pv[7]),
    .p9(pv[8]),   .p10(pv[9]),  .p11(pv[10]), .p12(pv[11]),
    .p13(pv[12]), .p14(pv[13]), .p15(pv[14]), .p16(pv[15])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: image store + window-hold bookkeeping
  int img [H][W];
  int m_win [16];
  bit m_valid;
  int m_beats, m_col, m_row, m_windows;

  // Observed window runs
  int   run_len [$];
  win_t win_seen [$];
  bit   prev_v;
  int   cur_len;

  task automatic model_reset();
    m_valid = 0; m_beats = 0; m_col = 0; m_row = 0;
  endtask

  task automatic model_tick(input bit v, input int pix, input bit rdy, input bit rb);
    bit acc;
    acc = v && !m_valid;
    if (m_valid) begin
      if (rb && (m_beats > 0 || rdy)) m_beats++;
      if (m_beats == 16) begin m_valid = 0; m_beats = 0; end
    end
    if (acc) begin
      img[m_row][m_col] = pix;
      if (m_col >= 3 && m_row >= 3) begin
        m_valid = 1;
        m_windows++;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            m_win[4*i+j] = img[m_row-3+i][m_col-3+j];
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else m_col++;
    end
  endtask

  task automatic record();
    if (bf_req_valid && !prev_v) begin win_seen.push_back(pv); cur_len = 0; end
    if (bf_req_valid) cur_len++;
    else if (prev_v) run_len.push_back(cur_len);
    prev_v = bf_req_valid;
  endtask

  task automatic clear_obs();
    run_len.delete(); win_seen.delete();
  endtask

  // mode 0: always ready/beat; 1: ready low for first 5 hold cycles;
  // 2: rsp_beat on odd hold cycles; 3: random everything.
  // Pattern pixels: base + 100*frame_index + 8r + c.
  task automatic stream(input int base, input int mode, input int npix);
    int acc_cnt, hc, cyc, pix;
    bit v, rdy, rb;
    acc_cnt = 0; hc = 0; cyc = 0;
    while ((acc_cnt < npix || m_valid) && cyc < 3000) begin
      @(negedge clk); cyc++;
      n_cmp++;
      if (in_ready !== !m_valid) begin
        n_err++; $display("FAIL stream_in_ready: got %b want %b", in_ready, !m_valid);
      end
      n_cmp++;
      if (bf_req_valid !== m_valid) begin
        n_err++; $display("FAIL stream_valid: got %b want %b", bf_req_valid, m_valid);
      end
      if (m_valid)
        for (int k = 0; k < 16; k++) begin
          n_cmp++;
          if (pv[k] !== CW'(m_win[k])) begin
            n_err++; $display("FAIL stream_p%0d: got %0d want %0d", k+1, pv[k], m_win[k]);
          end
        end
      record();
      if (!m_valid) hc = 0;
      v   = (acc_cnt < npix) && (mode != 3 || $urandom_range(0, 1) == 1);
      pix = (mode == 3) ? int'($urandom_range(0, 255))
                        : base + 100 * (acc_cnt / FRAME) + 8 * m_row + m_col;
      rdy = (mode == 1) ? (hc >= 5) : (mode == 3) ? ($urandom_range(0, 1) == 1) : 1'b1;
      rb  = (mode == 2) ? (hc % 2 == 1) : (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v; in_pixel = CW'(pix); bcci_req_ready = rdy; rsp_beat = rb;
      if (v && !m_valid) acc_cnt++;
      if (m_valid) hc++;
      model_tick(v, pix, rdy, rb);
    end
    if (cyc >= 3000) begin
      n_cmp++; n_err++; $display("FAIL stream_timeout: got %0d accepted want %0d", acc_cnt, npix);
    end
    @(negedge clk);
    n_cmp++;
    if (bf_req_valid !== m_valid) begin
      n_err++; $display("FAIL stream_drain: got %b want %b", bf_req_valid, m_valid);
    end
    record();
    in_valid = 0; rsp_beat = 0; bcci_req_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (bf_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bf_req_valid); end
    n_cmp++; if (pv !== '0) begin n_err++; $display("FAIL reset_p: got %h want 0", pv); end
    rst_n = 1;
    model_reset(); prev_v = 0;
  endtask

  task automatic test_first_window();
    int w0;
    clear_obs(); w0 = m_windows;
    stream(0, 0, FRAME);
    n_cmp++; if (win_seen.size() != 15 || m_windows - w0 != 15) begin
      n_err++; $display("FAIL first_count: got %0d want 15", win_seen.size()); end
    if (win_seen.size() >= 2 && run_len.size() >= 1) begin
      n_cmp++; if (win_seen[0][3:0] !== {8'd3, 8'd2, 8'd1, 8'd0}) begin
        n_err++; $display("FAIL first_p1_4: got %h want 03020100", win_seen[0][3:0]); end
      n_cmp++; if (win_seen[0][4] !== 8'd8) begin n_err++; $display("FAIL first_p5: got %0d want 8", win_seen[0][4]); end
      n_cmp++; if (win_seen[0][12] !== 8'd24) begin n_err++; $display("FAIL first_p13: got %0d want 24", win_seen[0][12]); end
      n_cmp++; if (win_seen[0][15] !== 8'd27) begin n_err++; $display("FAIL first_p16: got %0d want 27", win_seen[0][15]); end
      n_cmp++; if (win_seen[1][3:0] !== {8'd4, 8'd3, 8'd2, 8'd1}) begin
        n_err++; $display("FAIL second_p1_4: got %h want 04030201", win_seen[1][3:0]); end
      n_cmp++; if (win_seen[1][15] !== 8'd28) begin n_err++; $display("FAIL second_p16: got %0d want 28", win_seen[1][15]); end
      foreach (run_len[i]) begin
        n_cmp++; if (run_len[i] != 16) begin n_err++; $display("FAIL first_runlen: got %0d want 16", run_len[i]); end
      end
    end else begin
      n_cmp++; n_err++; $display("FAIL first_windows_seen: got %0d want 15", win_seen.size());
    end
  endtask

  task automatic test_stall_ready();
    clear_obs();
    stream(0, 1, FRAME);
    n_cmp++; if (run_len.size() != 15) begin n_err++; $display("FAIL stall_count: got %0d want 15", run_len.size()); end
    foreach (run_len[i]) begin
      n_cmp++; if (run_len[i] != 21) begin n_err++; $display("FAIL stall_runlen: got %0d want 21", run_len[i]); end
    end
  endtask

  task automatic test_toggle_beat();
    clear_obs();
    stream(0, 2, FRAME);
    n_cmp++; if (run_len.size() != 15) begin n_err++; $display("FAIL toggle_count: got %0d want 15", run_len.size()); end
    foreach (run_len[i]) begin
      n_cmp++; if (run_len[i] != 32) begin n_err++; $display("FAIL toggle_runlen: got %0d want 32", run_len[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    stream(0, 0, 2 * FRAME);
    n_cmp++; if (win_seen.size() != 30) begin n_err++; $display("FAIL b2b_count: got %0d want 30", win_seen.size()); end
    if (win_seen.size() >= 16) begin
      n_cmp++; if (win_seen[14][15] !== 8'd47) begin n_err++; $display("FAIL b2b_last_p16: got %0d want 47", win_seen[14][15]); end
      n_cmp++; if (win_seen[15][0] !== 8'd100) begin n_err++; $display("FAIL b2b_f2_p1: got %0d want 100", win_seen[15][0]); end
      n_cmp++; if (win_seen[15][15] !== 8'd127) begin n_err++; $display("FAIL b2b_f2_p16: got %0d want 127", win_seen[15][15]); end
    end
  endtask

  task automatic test_random();
    clear_obs();
    stream(0, 3, 3 * FRAME);
    n_cmp++; if (win_seen.size() != 45) begin n_err++; $display("FAIL random_count: got %0d want 45", win_seen.size()); end
  endtask

  task automatic test_reset_mid_hold();
    int cyc, pix;
    cyc = 0;
    while (!(m_valid && m_beats == 7) && cyc < 500) begin
      @(negedge clk); cyc++;
      n_cmp++;
      if (bf_req_valid !== m_valid) begin n_err++; $display("FAIL rsthold_valid: got %b want %b", bf_req_valid, m_valid); end
      pix = 8 * m_row + m_col;
      in_valid = 1; in_pixel = CW'(pix); bcci_req_ready = 1; rsp_beat = 1;
      model_tick(1'b1, pix, 1'b1, 1'b1);
    end
    if (cyc >= 500) begin n_cmp++; n_err++; $display("FAIL rsthold_timeout: got %0d cycles want <500", cyc); end
    @(negedge clk);
    n_cmp++; if (bf_req_valid !== 1'b1) begin n_err++; $display("FAIL rsthold_pre: got %b want 1", bf_req_valid); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (bf_req_valid !== 1'b0) begin n_err++; $display("FAIL rsthold_valid_async: got %b want 0", bf_req_valid); end
    n_cmp++; if (pv !== '0) begin n_err++; $display("FAIL rsthold_p_async: got %h want 0", pv); end
    model_reset(); prev_v = 0;
    @(negedge clk);
    rst_n = 1; in_valid = 0; rsp_beat = 0; bcci_req_ready = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rsthold_in_ready: got %b want 1", in_ready); end
    clear_obs();
    stream(0, 0, FRAME);
    n_cmp++; if (win_seen.size() != 15) begin n_err++; $display("FAIL rsthold_count: got %0d want 15", win_seen.size()); end
    if (win_seen.size() >= 1) begin
      n_cmp++; if (win_seen[0][0] !== 8'd0) begin n_err++; $display("FAIL rsthold_p1: got %0d want 0", win_seen[0][0]); end
      n_cmp++; if (win_seen[0][15] !== 8'd27) begin n_err++; $display("FAIL rsthold_p16: got %0d want 27", win_seen[0][15]); end
    end
  endtask

  initial begin
    m_windows = 0; prev_v = 0; cur_len = 0;
    model_reset();
    test_reset();
    test_first_window();
    test_stall_ready();
    test_toggle_beat();
    test_back_to_back();
    test_random();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
